// File: rtl/acc_arg_fetch.sv
// rtl/acc_arg_fetch.sv - streams COUNT words from the arg RAM starting at BASE
// CSR-launched fetcher with a 2-entry output FIFO and abort/done status.
module acc_arg_fetch #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_write,
    input  logic              csr_read,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    output logic              st_last,
    input  logic              st_ready,
    output logic              irq
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     issued;
    logic                done;
    logic                aborted;
    logic                inflight;
    logic                inflight_last;

    logic [DATA_W-1:0]   fifo_data [2];
    logic [1:0]          fifo_last;
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          fifo_count;

    logic                wr_ctrl, wr_base, wr_count, wr_status;
    logic                start_req, abort_req;
    logic                push, pop;
    logic [2:0]          occupancy;
    logic                issue, last_issue, last_pop, done_set;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign unused_wdata = ^csr_writedata[31:ADDR_W+1];

    assign wr_ctrl   = csr_write && (csr_address == 2'd0);
    assign wr_base   = csr_write && (csr_address == 2'd1) && (state == IDLE);
    assign wr_count  = csr_write && (csr_address == 2'd2) && (state == IDLE);
    assign wr_status = csr_write && (csr_address == 2'd3);

    // abort beats start when both bits arrive in one write
    assign abort_req = wr_ctrl && csr_writedata[1] && (state != IDLE);
    assign start_req = wr_ctrl && csr_writedata[0] && !csr_writedata[1] && (state == IDLE);

    assign pop  = st_valid && st_ready;
    assign push = inflight && !abort_req;

    // slots already spoken for after this edge, excluding a new issue
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == FETCH) && !abort_req && (issued < count) && (occupancy < 3'd2);
    assign last_issue = issue && (issued == count - 1'b1);
    assign last_pop   = pop && st_last;
    assign done_set   = (start_req && (count == '0)) ||
                        ((state == DRAIN) && !abort_req && last_pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req && (count != '0)) state_nxt = FETCH;
            FETCH:   if (abort_req) state_nxt = IDLE;
                     else if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (abort_req || last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            base          <= '0;
            count         <= '0;
            issued        <= '0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= last_issue;
            if (wr_base)  base  <= csr_writedata[ADDR_W-1:0];
            if (wr_count) count <= csr_writedata[ADDR_W:0];
            if (start_req)  issued <= '0;
            else if (issue) issued <= issued + 1'b1;
            if (done_set)                             done <= 1'b1;
            else if (wr_status && csr_writedata[1])   done <= 1'b0;
            if (abort_req)                            aborted <= 1'b1;
            else if (wr_status && csr_writedata[2])   aborted <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            fifo_last  <= 2'b00;
        end else if (abort_req) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // payload needs no reset: it is only observed behind fifo_count
    always_ff @(posedge clk) begin
        if (push) fifo_data[wr_ptr] <= ram_readdata;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (csr_address)
            2'd1:    rd_mux = 32'(base);
            2'd2:    rd_mux = 32'(count);
            2'd3:    rd_mux = {29'd0, aborted, done, (state != IDLE)};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     csr_readdata <= 32'd0;
        else if (csr_read) csr_readdata <= rd_mux;
        else               csr_readdata <= 32'd0;
    end

    assign ram_address    = base + issued[ADDR_W-1:0];
    assign ram_chipselect = issue;
    assign ram_clken      = issue;
    assign ram_write      = 1'b0;
    assign st_valid       = (fifo_count != 2'd0);
    assign st_data        = fifo_data[rd_ptr];
    assign st_last        = st_valid && fifo_last[rd_ptr];
    assign irq            = done;

endmodule

// File: tb/tb_acc_arg_fetch.sv
// tb/tb_acc_arg_fetch.sv - directed and randomized checks of acc_arg_fetch
module tb_acc_arg_fetch;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        csr_address = '0;
    logic              csr_write = 1'b0;
    logic              csr_read = 1'b0;
    logic [31:0]       csr_writedata = '0;
    logic [31:0]       csr_readdata;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_clken;
    logic              ram_write;
    logic [DATA_W-1:0] ram_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_last;
    logic              st_ready = 1'b0;
    logic              irq;

    acc_arg_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_clken(ram_clken), .ram_write(ram_write), .ram_readdata(ram_readdata),
        .st_data(st_data), .st_valid(st_valid), .st_last(st_last),
        .st_ready(st_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q = '0;
    always @(posedge clk) if (ram_chipselect && ram_clken && !ram_write) ram_q <= mem[ram_address];
    assign ram_readdata = ram_q;

    typedef struct {logic [DATA_W-1:0] data; logic last; int cyc;} beat_t;
    beat_t             beats[$];
    logic              stab_en = 1'b0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              cs_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_chipselect) cs_seen = 1'b1;
        if (stab_en && prev_stall) begin
            chk("stall_valid", 64'(st_valid), 64'd1);
            chk("stall_data", st_data, prev_data);
        end
        prev_stall = st_valid && !st_ready;
        prev_data  = st_data;
        if (reset_n && st_valid && st_ready) beats.push_back(beat_t'{st_data, st_last, cyc});
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a; csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic wait_irq(input string tag, input int bound);
        int k = 0;
        while (irq !== 1'b1 && k < bound) begin tick(1); k++; end
        chk(tag, 64'(irq), 64'd1);
    endtask

    task automatic start_run(input int b, input int n);
        csr_wr(2'd1, 32'(b));
        csr_wr(2'd2, 32'(n));
        beats.delete();
        csr_wr(2'd0, 32'd1);
    endtask

    // reference: word i of a run is RAM[(BASE+i) mod depth], last only on word COUNT-1
    task automatic check_stream(input string tag, input int b, input int n);
        chk({tag, "_count"}, 64'(beats.size()), 64'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk({tag, "_data"}, beats[i].data, mem[(b + i) % DEPTH]);
            chk({tag, "_last"}, 64'(beats[i].last), 64'(i == n - 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] r;
    int b, n, k;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i);

        #1;
        chk("rst_valid", 64'(st_valid), 64'd0);
        chk("rst_last", 64'(st_last), 64'd0);
        chk("rst_cs", 64'(ram_chipselect), 64'd0);
        chk("rst_clken", 64'(ram_clken), 64'd0);
        chk("rst_rdata", 64'(csr_readdata), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_ramwr", 64'(ram_write), 64'd0);
        tick(3);
        reset_n = 1'b1;
        tick(1);
        csr_rd(2'd3, r); chk("rst_status", 64'(r), 64'd0);
        csr_rd(2'd1, r); chk("rst_base", 64'(r), 64'd0);
        csr_rd(2'd2, r); chk("rst_count", 64'(r), 64'd0);

        // basic run with latency and throughput
        st_ready = 1'b1;
        csr_wr(2'd1, 32'd5);
        csr_wr(2'd2, 32'd4);
        csr_rd(2'd1, r); chk("base_rb", 64'(r), 64'd5);
        csr_rd(2'd2, r); chk("count_rb", 64'(r), 64'd4);
        beats.delete();
        csr_wr(2'd0, 32'd1);
        chk("lat_c1", 64'(st_valid), 64'd0);
        tick(1);
        chk("lat_c2", 64'(st_valid), 64'd0);
        tick(1);
        chk("lat_c3", 64'(st_valid), 64'd1);
        chk("lat_data", st_data, 64'd5);
        wait_irq("b34_done", 50);
        check_stream("b34", 5, 4);
        if (beats.size() == 4) chk("b34_back2back", 64'(beats[3].cyc - beats[0].cyc), 64'd3);
        csr_rd(2'd3, r); chk("b34_status", 64'(r), 64'd2);
        chk("b34_idle_valid", 64'(st_valid), 64'd0);
        csr_wr(2'd3, 32'd2);
        csr_rd(2'd3, r); chk("done_clr", 64'(r), 64'd0);
        chk("irq_clr", 64'(irq), 64'd0);

        // address wrap
        start_run(1022, 4);
        wait_irq("wrap_done", 50);
        check_stream("wrap", 1022, 4);
        csr_wr(2'd3, 32'd2);

        // random back-pressure
        for (int it = 0; it < 4; it++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = (it == 0) ? 16 : $urandom_range(1, 40);
            stab_en = 1'b1;
            start_run(b, n);
            k = 0;
            while (irq !== 1'b1 && k < 800) begin
                st_ready = 1'($urandom_range(0, 1));
                tick(1);
                k++;
            end
            chk("rnd_done", 64'(irq), 64'd1);
            st_ready = 1'b1;
            tick(3);
            stab_en = 1'b0;
            check_stream("rnd", b, n);
            csr_wr(2'd3, 32'd2);
        end

        // busy protection and abort after 3 beats
        st_ready = 1'b0;
        start_run(100, 10);
        tick(4);
        csr_rd(2'd3, r); chk("busy_status", 64'(r), 64'd1);
        csr_wr(2'd1, 32'd200);
        csr_rd(2'd1, r); chk("busy_base", 64'(r), 64'd100);
        csr_wr(2'd2, 32'd3);
        csr_rd(2'd2, r); chk("busy_count", 64'(r), 64'd10);
        csr_wr(2'd0, 32'd1);
        k = 0;
        while (beats.size() < 3 && k < 100) begin st_ready = 1'b1; tick(1); k++; end
        st_ready = 1'b0;
        chk("abort_pre_n", 64'(beats.size()), 64'd3);
        csr_wr(2'd0, 32'd2);
        chk("abort_valid", 64'(st_valid), 64'd0);
        cs_seen = 1'b0;
        st_ready = 1'b1;
        tick(10);
        chk("abort_beats", 64'(beats.size()), 64'd3);
        chk("abort_cs", 64'(cs_seen), 64'd0);
        for (int i = 0; i < 3 && i < beats.size(); i++) begin
            chk("abort_data", beats[i].data, 64'(100 + i));
            chk("abort_last", 64'(beats[i].last), 64'd0);
        end
        csr_rd(2'd3, r); chk("abort_status", 64'(r), 64'd4);
        chk("abort_irq", 64'(irq), 64'd0);
        csr_wr(2'd3, 32'd4);
        start_run(50, 2);
        wait_irq("post_abort_done", 50);
        check_stream("post_abort", 50, 2);
        csr_rd(2'd3, r); chk("post_abort_status", 64'(r), 64'd2);
        csr_wr(2'd3, 32'd2);

        // start+abort together, and abort alone, while idle
        cs_seen = 1'b0;
        csr_wr(2'd2, 32'd2);
        csr_wr(2'd0, 32'd3);
        tick(3);
        csr_rd(2'd3, r); chk("start_abort_idle", 64'(r), 64'd0);
        csr_wr(2'd0, 32'd2);
        csr_rd(2'd3, r); chk("abort_idle", 64'(r), 64'd0);
        chk("start_abort_cs", 64'(cs_seen), 64'd0);

        // zero-length start
        csr_wr(2'd2, 32'd0);
        csr_wr(2'd0, 32'd1);
        chk("zero_irq", 64'(irq), 64'd1);
        tick(3);
        chk("zero_cs", 64'(cs_seen), 64'd0);
        csr_rd(2'd3, r); chk("zero_status", 64'(r), 64'd2);
        csr_wr(2'd3, 32'd2);

        // software clear on the same edge that hardware sets done
        st_ready = 1'b1;
        csr_wr(2'd1, 32'd7);
        csr_wr(2'd2, 32'd1);
        beats.delete();
        csr_wr(2'd0, 32'd1);
        tick(2);
        chk("race_valid", 64'(st_valid), 64'd1);
        chk("race_last", 64'(st_last), 64'd1);
        csr_wr(2'd3, 32'd2);
        chk("race_set_wins", 64'(irq), 64'd1);
        csr_wr(2'd3, 32'd2);
        chk("race_clr", 64'(irq), 64'd0);

        // reset mid-transfer
        start_run(0, 20);
        tick(5);
        csr_address = 2'd3; csr_read = 1'b1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(st_valid), 64'd0);
        chk("mrst_last", 64'(st_last), 64'd0);
        chk("mrst_cs", 64'(ram_chipselect), 64'd0);
        chk("mrst_clken", 64'(ram_clken), 64'd0);
        chk("mrst_rdata", 64'(csr_readdata), 64'd0);
        chk("mrst_irq", 64'(irq), 64'd0);
        csr_read = 1'b0;
        tick(2);
        reset_n = 1'b1;
        beats.delete();
        tick(20);
        chk("mrst_no_beats", 64'(beats.size()), 64'd0);
        csr_rd(2'd3, r); chk("mrst_status", 64'(r), 64'd0);
        csr_rd(2'd1, r); chk("mrst_base", 64'(r), 64'd0);
        csr_rd(2'd2, r); chk("mrst_count", 64'(r), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
